// File: rtl/cpu_dmem_interface.sv
// Data-memory interface between the MEM stage and the data bus: byte-lane steering,
// a req/gnt/rvalid handshake with a bounded wait, and a pipeline stall per access.
module cpu_dmem_interface #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_we,
    input  logic        core_re,
    input  logic [1:0]  core_size,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_fault,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    // Last counter value at which the access may still wait before it is aborted.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;
    logic [1:0]  off_q, off_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  off;
    logic        is_wr, is_rd, bad, req_ok, req_bad, timeout_hit;
    logic [3:0]  mask;

    always_comb begin : decode
        off   = core_addr[1:0];
        is_wr = |core_we;
        is_rd = core_re & ~is_wr;
        mask  = 4'b0000;
        bad   = 1'b0;
        if (is_wr) begin
            mask = core_we;
            case (core_we)
                4'b0001: bad = 1'b0;
                4'b0011: bad = off[0];
                4'b1111: bad = |off;
                default: bad = 1'b1;
            endcase
        end else begin
            case (core_size)
                2'b00:   mask = 4'b0001;
                2'b01:   begin mask = 4'b0011; bad = off[0]; end
                2'b10:   begin mask = 4'b1111; bad = |off;   end
                default: bad = 1'b1;
            endcase
        end
        req_ok      = (is_wr | is_rd) & ~bad;
        req_bad     = (is_wr | is_rd) & bad;
        timeout_hit = (cnt_q >= TO_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            to_q        <= 1'b0;
            off_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin : next_state
        // NOTE: every _d starts from its _q so no branch of the case can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d     = REQ;
                    cnt_d       = '0;
                    off_d       = off;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = {core_addr[31:2], 2'b00};
                    bus_we_d    = is_wr;
                    bus_be_d    = mask << off;
                    bus_wdata_d = core_wdata << {off, 3'b000};
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = bus_we_q ? DONE : WAIT;
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
                    to_d      = 1'b1;
                    state_d   = DONE;
                    if (!bus_we_q) rdata_d = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_rvalid) begin
                    rdata_d = bus_rdata >> {off_q, 3'b000};
                    state_d = DONE;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                to_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational outputs are gated by reset so they also read 0 while reset is held.
    always_comb begin : outputs
        core_stall = 1'b0;
        core_fault = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE:      begin core_stall = req_ok; core_fault = req_bad; end
                REQ, WAIT: core_stall = 1'b1;
                DONE:      core_fault = to_q;
                default:   core_stall = 1'b0;
            endcase
        end
    end

    assign core_rdata = rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_addr   = bus_addr_q;
    assign bus_we     = bus_we_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_cpu_dmem_interface.sv
// Bench for cpu_dmem_interface: directed handshake scenarios, then randomized accesses
// checked against an arithmetic model of lane steering and load alignment.
module tb_cpu_dmem_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_addr, core_wdata, bus_rdata;
    logic [3:0]  core_we;
    logic        core_re, bus_gnt, bus_rvalid;
    logic [1:0]  core_size;

    logic [31:0] core_rdata, bus_addr, bus_wdata;
    logic        core_stall, core_fault, bus_req, bus_we;
    logic [3:0]  bus_be;

    logic [31:0] t4_core_rdata, t4_bus_addr, t4_bus_wdata;
    logic        t4_core_stall, t4_core_fault, t4_bus_req, t4_bus_we;
    logic [3:0]  t4_bus_be;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    cpu_dmem_interface dut (
        .clk(clk), .reset(reset),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
        .core_re(core_re), .core_size(core_size), .core_rdata(core_rdata),
        .core_stall(core_stall), .core_fault(core_fault),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    cpu_dmem_interface #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .reset(reset),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
        .core_re(core_re), .core_size(core_size), .core_rdata(t4_core_rdata),
        .core_stall(t4_core_stall), .core_fault(t4_core_fault),
        .bus_req(t4_bus_req), .bus_addr(t4_bus_addr), .bus_we(t4_bus_we), .bus_be(t4_bus_be),
        .bus_wdata(t4_bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        core_re    = 1'b0;
        core_we    = 4'b0000;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    // Reference: access width in bytes, natural alignment, lane placement by multiplication.
    function automatic void model(input logic [31:0] addr, input logic [3:0] we, input logic re,
                                  input logic [1:0] size, input logic [31:0] wd,
                                  output bit act, output bit flt, output bit wr,
                                  output logic [3:0] be, output logic [31:0] bwd);
        int nbytes;
        int off;
        off = int'(addr[1:0]);
        wr  = (we != 4'b0000);
        act = wr || (re == 1'b1);
        if (wr) nbytes = (we == 4'b0001) ? 1 : (we == 4'b0011) ? 2 : (we == 4'b1111) ? 4 : 0;
        else    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        flt = act && (nbytes == 0 || (off % nbytes) != 0);
        be  = flt ? 4'b0000 : 4'(((2 ** nbytes) - 1) * (2 ** off));
        bwd = 32'(longint'(wd) * (longint'(1) << (8 * off)));
    endfunction

    task automatic run_txn(input logic [31:0] addr, input logic [3:0] we, input logic re,
                           input logic [1:0] size, input logic [31:0] wd,
                           input int gdly, input int rdly, input logic [31:0] rd);
        bit          act, flt, wr;
        logic [3:0]  be;
        logic [31:0] bwd, exp_ld;
        model(addr, we, re, size, wd, act, flt, wr, be, bwd);
        exp_ld = 32'(longint'(rd) / (longint'(1) << (8 * int'(addr[1:0]))));
        core_addr = addr; core_we = we; core_re = re; core_size = size; core_wdata = wd;
        mid();
        check("rnd_c0_stall", core_stall, (act && !flt) ? 1 : 0);
        check("rnd_c0_fault", core_fault, flt ? 1 : 0);
        if (flt) begin
            next(); idle();
            mid();
            check("rnd_flt_req", bus_req, 0);
            check("rnd_flt_rdata", core_rdata, last_rdata);
            next();
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                next();
                bus_gnt    = (i == gdly);
                bus_rvalid = 1'($urandom_range(0, 1));
                bus_rdata  = $urandom;
                mid();
                check("rnd_req", bus_req, 1);
                check("rnd_addr", bus_addr, {addr[31:2], 2'b00});
                check("rnd_be", bus_be, be);
                check("rnd_we", bus_we, wr ? 1 : 0);
                check("rnd_stall", core_stall, 1);
                if (wr) check("rnd_wdata", bus_wdata, bwd);
            end
            next();
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (!wr) begin
                for (int j = 0; j <= rdly; j++) begin
                    bus_rvalid = (j == rdly);
                    bus_rdata  = (j == rdly) ? rd : $urandom;
                    mid();
                    check("rnd_wait_stall", core_stall, 1);
                    check("rnd_wait_req", bus_req, 0);
                    next();
                end
                last_rdata = exp_ld;
            end
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom;
            mid();
            check("rnd_done_stall", core_stall, 0);
            check("rnd_done_fault", core_fault, 0);
            check("rnd_done_req", bus_req, 0);
            check("rnd_done_rdata", core_rdata, last_rdata);
            next(); idle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] a, w_data, r_data;
        logic [3:0]  w;
        logic        r;
        logic [1:0]  s;

        reset = 1'b0; idle();
        core_addr = '0; core_wdata = '0; core_size = '0; bus_rdata = '0;
        mid();
        check("rst_rdata", core_rdata, 0);
        check("rst_stall", core_stall, 0);
        check("rst_fault", core_fault, 0);
        check("rst_req", bus_req, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_we", bus_we, 0);
        check("rst_be", bus_be, 0);
        check("rst_wdata", bus_wdata, 0);
        #2 reset = 1'b1;
        next();

        // SB to 0x1003, zero-wait grant
        core_addr = 32'h1003; core_we = 4'b0001; core_wdata = 32'hAB; core_re = 1'b0;
        mid();
        check("sb_c0_stall", core_stall, 1);
        check("sb_c0_req", bus_req, 0);
        next(); bus_gnt = 1'b1;
        mid();
        check("sb_c1_req", bus_req, 1);
        check("sb_c1_addr", bus_addr, 32'h1000);
        check("sb_c1_be", bus_be, 4'b1000);
        check("sb_c1_we", bus_we, 1);
        check("sb_c1_wdata", bus_wdata, 32'hAB00_0000);
        check("sb_c1_t4_wdata", t4_bus_wdata, 32'hAB00_0000);
        check("sb_c1_stall", core_stall, 1);
        next(); bus_gnt = 1'b0;
        mid();
        check("sb_c2_stall", core_stall, 0);
        check("sb_c2_req", bus_req, 0);
        check("sb_c2_fault", core_fault, 0);
        next(); idle();

        // LH from 0x2002, rvalid the cycle after grant
        core_addr = 32'h2002; core_re = 1'b1; core_size = 2'b01;
        mid();
        check("lh_c0_stall", core_stall, 1);
        next(); bus_gnt = 1'b1;
        mid();
        check("lh_c1_be", bus_be, 4'b1100);
        check("lh_c1_we", bus_we, 0);
        check("lh_c1_addr", bus_addr, 32'h2000);
        check("lh_c1_stall", core_stall, 1);
        next(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h8001_1234;
        mid();
        check("lh_c2_stall", core_stall, 1);
        check("lh_c2_req", bus_req, 0);
        next(); bus_rvalid = 1'b0; bus_rdata = 32'hFFFF_FFFF;
        mid();
        check("lh_c3_stall", core_stall, 0);
        check("lh_c3_rdata", core_rdata, 32'h0000_8001);
        next(); idle();

        // Alignment faults: LW 0x3001, SH 0x1001, illegal byte-enable pattern
        core_addr = 32'h3001; core_re = 1'b1; core_size = 2'b10;
        mid();
        check("lw_mis_fault", core_fault, 1);
        check("lw_mis_stall", core_stall, 0);
        check("lw_mis_req", bus_req, 0);
        next(); idle(); core_addr = 32'h1001; core_we = 4'b0011;
        mid();
        check("sh_mis_fault", core_fault, 1);
        check("sh_mis_req", bus_req, 0);
        next(); core_addr = 32'h1000; core_we = 4'b0101;
        mid();
        check("we_bad_fault", core_fault, 1);
        check("we_bad_stall", core_stall, 0);
        next(); idle();
        mid();
        check("mis_after_fault", core_fault, 0);
        check("mis_after_req", bus_req, 0);
        check("mis_rdata_hold", core_rdata, 32'h0000_8001);
        next();

        // LB from 0x5001: grant delayed 3 cycles, rvalid two cycles after grant
        core_addr = 32'h5001; core_re = 1'b1; core_size = 2'b00;
        mid();
        check("dly_c0_stall", core_stall, 1);
        for (int i = 0; i < 4; i++) begin
            next(); bus_gnt = (i == 3);
            mid();
            check("dly_req", bus_req, 1);
            check("dly_addr", bus_addr, 32'h5000);
            check("dly_be", bus_be, 4'b0010);
            check("dly_stall", core_stall, 1);
        end
        next(); bus_gnt = 1'b0;
        mid();
        check("dly_c5_req", bus_req, 0);
        check("dly_c5_stall", core_stall, 1);
        next(); bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        mid();
        check("dly_c6_stall", core_stall, 1);
        next(); bus_rvalid = 1'b0;
        mid();
        check("dly_c7_stall", core_stall, 0);
        check("dly_c7_rdata", core_rdata, 32'h00CA_FEF0);
        next(); idle();
        repeat (8) next();

        // Zero-wait LW on both instances so the timeout below has data to clear
        core_addr = 32'h7000; core_re = 1'b1; core_size = 2'b10;
        next(); bus_gnt = 1'b1;
        next(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1357_2468;
        next(); bus_rvalid = 1'b0;
        mid();
        check("lw_rdata", core_rdata, 32'h1357_2468);
        check("lw_t4_rdata", t4_core_rdata, 32'h1357_2468);
        next(); idle();

        // TIMEOUT=4 instance, grant never given
        core_addr = 32'h7008; core_re = 1'b1; core_size = 2'b10;
        mid();
        check("to_c0_stall", t4_core_stall, 1);
        for (int i = 0; i < 4; i++) begin
            next();
            mid();
            check("to_req", t4_bus_req, 1);
            check("to_fault_low", t4_core_fault, 0);
        end
        check("to_addr", t4_bus_addr, 32'h7008);
        check("to_be", t4_bus_be, 4'b1111);
        check("to_we", t4_bus_we, 0);
        next();
        mid();
        check("to_done_req", t4_bus_req, 0);
        check("to_done_fault", t4_core_fault, 1);
        check("to_done_stall", t4_core_stall, 0);
        check("to_done_rdata", t4_core_rdata, 0);
        check("to_main_waiting", bus_req, 1);
        next(); core_re = 1'b0;
        mid();
        check("to_idle_fault", t4_core_fault, 0);
        check("to_idle_stall", t4_core_stall, 0);

        // Main instance into WAIT, then reset mid-access
        next(); core_re = 1'b1; bus_gnt = 1'b1;
        mid();
        check("rw_gnt_req", bus_req, 1);
        next(); bus_gnt = 1'b0;
        mid();
        check("rw_wait_stall", core_stall, 1);
        #1 core_addr = 32'h4000; reset = 1'b0;
        #1;
        check("rw_rst_stall", core_stall, 0);
        check("rw_rst_req", bus_req, 0);
        check("rw_rst_be", bus_be, 0);
        check("rw_rst_fault", core_fault, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("rw_rel_stall", core_stall, 1);
        next(); bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        mid();
        check("rw_req", bus_req, 1);
        check("rw_addr", bus_addr, 32'h4000);
        next(); bus_rvalid = 1'b0; bus_gnt = 1'b1;
        mid();
        check("rw_stray_ignored", bus_req, 1);
        next(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        mid();
        check("rw_wait_stall2", core_stall, 1);
        next(); bus_rvalid = 1'b0;
        mid();
        check("rw_done_stall", core_stall, 0);
        check("rw_done_rdata", core_rdata, 32'hDEAD_BEEF);
        next(); idle();
        last_rdata = 32'hDEAD_BEEF;

        // Randomized accesses against the reference model
        for (int n = 0; n < 40; n++) begin
            a = $urandom; w_data = $urandom; r_data = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            w = 4'b0000; r = 1'b0; s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: begin w = 4'b0001; r = 1'($urandom_range(0, 1)); end
                1: begin w = 4'b0011; r = 1'($urandom_range(0, 1)); end
                2: begin w = 4'b1111; r = 1'($urandom_range(0, 1)); end
                3: begin r = 1'b1; s = 2'b00; end
                4: begin r = 1'b1; s = 2'b01; end
                5: begin r = 1'b1; s = 2'b10; end
                6: begin r = 1'b1; s = 2'b11; end
                default: begin w = 4'($urandom_range(1, 15)); r = 1'($urandom_range(0, 1)); end
            endcase
            run_txn(a, w, r, s, w_data, $urandom_range(0, 3), $urandom_range(0, 3), r_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_dmem_interface.md
# cpu_dmem_interface

Data-memory interface stage that sits directly downstream of the CPU MEM stage. It takes the stage's raw address, write data and right-justified byte-enable request. It steers byte lanes by address offset and runs a request/grant/response handshake with the data-memory bus. It holds the pipeline with a stall until the access completes, and returns right-justified read data to the MEM stage for sign/zero extension.

## Interface
- TIMEOUT, 255, bus-wait cycles allowed in REQ+WAIT before the access is aborted with a fault (1..65535)
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately
- core_addr  in  32  byte address from MEM stage
- core_wdata  in  32  store data, right-justified
- core_we  in  4  store byte enables, right-justified (0001 SB, 0011 SH, 1111 SW); nonzero = write
- core_re  in  1  load request
- core_size  in  2  load size: 00 byte, 01 half, 10 word; 11 illegal
- core_rdata  out  32  load data, right-justified (lane-shifted down)
- core_stall  out  1  pipeline must hold MEM inputs stable while high
- core_fault  out  1  one-cycle pulse: misaligned, illegal size, or timeout
- bus_req  out  1  bus request
- bus_addr  out  32  word-aligned address ({core_addr[31:2],2'b00})
- bus_we  out  1  1 = write
- bus_be  out  4  lane-steered byte enables
- bus_wdata  out  32  lane-steered write data
- bus_gnt  in  1  bus accepts request this cycle
- bus_rvalid  in  1  read data valid; never earlier than the cycle after bus_gnt
- bus_rdata  in  32  read data, full word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Offset off = core_addr[1:0]. Write: bus_be = core_we << off, bus_wdata = core_wdata << 8*off. Read: mask = 0001/0011/1111 by size; bus_be = mask << off. Load data is bus_rdata >> 8*off, upper bytes zero.
- Misaligned: any of
  - halfword with off[0]=1
  - word with off≠0
  - core_we not in {0001,0011,1111}
  - core_size=11 on a read
  
  Result: core_fault pulses in that IDLE cycle, no bus traffic, core_stall stays 0, state remains IDLE.
- core_re and nonzero core_we together: the write wins and the read is ignored.
- IDLE: on a legal request, core_stall=1 combinationally. bus_addr/be/we/wdata are registered and the FSM moves to REQ.
- REQ: bus_req=1. Bus fields stay stable until bus_gnt. On gnt, a write goes to DONE (posted write) and a read goes to WAIT. bus_req drops the cycle after gnt.
- WAIT: on bus_rvalid, the shifted data is captured into core_rdata and the FSM moves to DONE.
- DONE: core_stall=0 for exactly one cycle and bus inputs are ignored; the FSM then returns to IDLE. The MEM inputs seen in DONE are the completed request and are not reissued.
- Timeout: a 16-bit counter runs in REQ and WAIT and clears on entry to REQ. When it reaches TIMEOUT:
  - bus_req drops
  - core_rdata=0
  - the FSM moves to DONE with core_fault=1 in DONE
- core_rdata holds its value until the next read completes or times out. Writes leave it unchanged.
- bus_rvalid in IDLE/REQ/DONE is ignored. bus_gnt outside REQ is ignored.
- Reset mid-access: the FSM goes to IDLE, bus_req drops asynchronously, and no response is expected from the abandoned transfer.

## Timing
- Reset values: core_rdata 0, core_stall 0, core_fault 0, bus_req 0, bus_addr 0, bus_we 0, bus_be 0, bus_wdata 0, state IDLE, counter 0.
- core_stall is combinational from inputs in IDLE and registered-state-driven elsewhere.
- Zero-wait read: C0 IDLE (stall), C1 REQ+gnt, C2 WAIT+rvalid, C3 DONE (stall low, data valid). The pipeline advances at the end of C3.
- Zero-wait write: C0 IDLE, C1 REQ+gnt, C2 DONE, i.e. 3 cycles.
- Back-to-back accesses: the next request is evaluated in the IDLE cycle after DONE. There is at most one outstanding transfer.
- core_fault is high for one cycle only: in IDLE for alignment faults, in DONE for timeouts.

## Test plan
- SB core_addr=0x1003, core_we=0001, core_wdata=0xAB, zero-wait gnt -> bus_be=1000, bus_wdata=0xAB000000, bus_addr=0x1000, stall high 2 cycles, DONE at C2.
- LH core_addr=0x2002, size=01, bus_rdata=0x8001_1234, rvalid the cycle after gnt -> core_rdata=0x00008001 in C3, bus_be=1100, stall low only in C3.
- LW core_addr=0x3001 -> core_fault pulse in C0, bus_req never asserts, stall 0.
- Read with gnt delayed 3 cycles and rvalid delayed 2 more -> bus fields stable throughout REQ, bus_req low after gnt, DONE 7 cycles after request, correct data.
- TIMEOUT=4, bus_gnt never asserted -> bus_req high 4 cycles then low, core_fault in DONE, core_rdata=0, return to IDLE.
- reset low during WAIT -> bus_req/core_stall 0 immediately; after release, a new LW at 0x4000 with rdata 0xDEADBEEF completes normally and a stray rvalid before the new gnt is ignored.
